// File: rtl/button_ctl.sv
// rtl/button_ctl.sv - push-button synchroniser, debouncer, arbiter and hold stretcher
//
// Conditions five raw board push-buttons into clean one-hot command levels
// for the hero controller. Each command is held long enough for the
// controller's slow divided clock to sample it.
//
// Ports:
//   clk                      system clock
//   rst                      asynchronous active-low reset
//   btn_up/left/right/down/center
//                            raw asynchronous button inputs
//   up/left/right/down/center
//                            registered command levels, one-hot or all zero
//   busy                     high while a command is latched (ACTIVE or GAP)
module button_ctl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HOLD_CYCLES     = 1400000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_up,
  input  logic btn_left,
  input  logic btn_right,
  input  logic btn_down,
  input  logic btn_center,
  output logic up,
  output logic left,
  output logic right,
  output logic down,
  output logic center,
  output logic busy
);

  localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [DB_W-1:0]   DB_MAX   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_GAP
  } state_t;

  // Bit order doubles as priority: bit 4 (up) wins over bit 0 (center).
  logic [4:0] btn_raw;
  assign btn_raw = {btn_up, btn_left, btn_right, btn_down, btn_center};

  logic [4:0]      sync1_q, sync1_d;
  logic [4:0]      sync2_q, sync2_d;
  logic [4:0]      stable_q, stable_d;
  logic [DB_W-1:0] db_cnt_q [5];
  logic [DB_W-1:0] db_cnt_d [5];

  state_t            state_q, state_d;
  logic [4:0]        sel_q, sel_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [4:0]        cmd_q, cmd_d;
  logic              busy_q, busy_d;
  logic [4:0]        pick;

  // Synchroniser and per-button debounce.
  always_comb begin
    sync1_d  = btn_raw;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    db_cnt_d = db_cnt_q;
    for (int i = 0; i < 5; i++) begin
      if (sync2_q[i] == stable_q[i]) begin
        // Any bounce back to the stable level restarts the count.
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DB_MAX) begin
        stable_d[i] = sync2_q[i];
        db_cnt_d[i] = '0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      for (int i = 0; i < 5; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      for (int i = 0; i < 5; i++) db_cnt_q[i] <= db_cnt_d[i];
    end
  end

  // Fixed-priority pick among currently stable buttons.
  always_comb begin
    pick = '0;
    if (stable_q[4])      pick = 5'b10000;
    else if (stable_q[3]) pick = 5'b01000;
    else if (stable_q[2]) pick = 5'b00100;
    else if (stable_q[1]) pick = 5'b00010;
    else if (stable_q[0]) pick = 5'b00001;
  end

  // Outputs are computed from the next state so they register alongside it.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    hold_cnt_d = hold_cnt_q;
    cmd_d      = '0;
    busy_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|stable_q) begin
          sel_d      = pick;
          hold_cnt_d = HOLD_MAX;
          state_d    = S_ACTIVE;
          cmd_d      = pick;
          busy_d     = 1'b1;
        end
      end
      S_ACTIVE: begin
        busy_d = 1'b1;
        if (hold_cnt_q != '0) hold_cnt_d = hold_cnt_q - HOLD_W'(1);
        // Only the latched button's release matters; others are ignored.
        if ((hold_cnt_q == '0) && ((stable_q & sel_q) == '0)) begin
          state_d = S_GAP;
        end else begin
          cmd_d = sel_q;
        end
      end
      S_GAP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      sel_q      <= '0;
      hold_cnt_q <= '0;
      cmd_q      <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      hold_cnt_q <= hold_cnt_d;
      cmd_q      <= cmd_d;
      busy_q     <= busy_d;
    end
  end

  assign up     = cmd_q[4];
  assign left   = cmd_q[3];
  assign right  = cmd_q[2];
  assign down   = cmd_q[1];
  assign center = cmd_q[0];
  assign busy   = busy_q;

endmodule

// File: tb/tb_button_ctl.sv
// tb/tb_button_ctl.sv - directed table-driven bench for button_ctl
module tb_button_ctl;

  logic clk = 1'b0;
  logic rst;
  logic btn_up, btn_left, btn_right, btn_down, btn_center;
  logic up, left, right, down, center, busy;

  always #5 clk = ~clk;

  button_ctl #(
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES    (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_up    (btn_up),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .btn_down  (btn_down),
    .btn_center(btn_center),
    .up        (up),
    .left      (left),
    .right     (right),
    .down      (down),
    .center    (center),
    .busy      (busy)
  );

  // Button vectors: {up,left,right,down,center}
  localparam logic [4:0] B_NO = 5'b00000;
  localparam logic [4:0] B_UP = 5'b10000;
  localparam logic [4:0] B_LF = 5'b01000;
  localparam logic [4:0] B_RT = 5'b00100;
  localparam logic [4:0] B_DN = 5'b00010;
  localparam logic [4:0] B_CN = 5'b00001;

  // Expected outputs: {up,left,right,down,center,busy}
  localparam logic [5:0] E_IDLE = 6'b000000;
  localparam logic [5:0] E_GAP  = 6'b000001;
  localparam logic [5:0] E_UP   = 6'b100001;
  localparam logic [5:0] E_LF   = 6'b010001;
  localparam logic [5:0] E_RT   = 6'b001001;
  localparam logic [5:0] E_DN   = 6'b000101;
  localparam logic [5:0] E_CN   = 6'b000011;

  typedef struct {
    logic [4:0] btn;
    int         n;
    logic [5:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   errors = 0;
  int   checks = 0;

  task automatic add(input logic [4:0] b, input int n, input logic [5:0] e);
    vec_t v;
    v.btn = b;
    v.n   = n;
    v.exp = e;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic [4:0] b);
    {btn_up, btn_left, btn_right, btn_down, btn_center} = b;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input int idx, input logic [5:0] e);
    logic [5:0] act;
    act = {up, left, right, down, center, busy};
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s[%0d]: outputs {u,l,r,d,c,busy}=%b expected %b at %0t", name, idx, act, e, $time);
    end
  endtask

  initial begin
    // Reset held with btn_up pressed: everything stays 0.
    rst = 1'b0;
    drive(B_UP);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      step();
      check("reset_hold", k, E_IDLE);
    end
    rst = 1'b1;
    // up must rise at edge 7 after release, not earlier.
    for (int k = 1; k <= 7; k++) begin
      step();
      check("reset_release", k, (k >= 7) ? E_UP : E_IDLE);
    end

    // Release up one cycle after it rose: 8-cycle assertion, GAP, IDLE.
    add(B_NO, 7, E_UP);
    add(B_NO, 1, E_GAP);
    add(B_NO, 3, E_IDLE);
    // Debounce reject: a 3-cycle tap never asserts.
    add(B_LF, 3, E_IDLE);
    add(B_NO, 10, E_IDLE);
    // Held 20 cycles: left rises exactly at the 7th edge.
    add(B_LF, 6, E_IDLE);
    add(B_LF, 1, E_LF);
    add(B_LF, 13, E_LF);
    add(B_NO, 6, E_LF);
    add(B_NO, 1, E_GAP);
    add(B_NO, 3, E_IDLE);
    // Hold stretch: released right after down rises, still 8 cycles high.
    add(B_DN, 6, E_IDLE);
    add(B_DN, 1, E_DN);
    add(B_NO, 7, E_DN);
    add(B_NO, 1, E_GAP);
    add(B_NO, 3, E_IDLE);
    // Priority: up beats right; right follows via GAP/IDLE once up is released.
    add(B_UP | B_RT, 6, E_IDLE);
    add(B_UP | B_RT, 1, E_UP);
    add(B_UP | B_RT, 23, E_UP);
    add(B_RT, 6, E_UP);
    add(B_RT, 1, E_GAP);
    add(B_RT, 1, E_IDLE);
    add(B_RT, 1, E_RT);
    add(B_NO, 7, E_RT);
    add(B_NO, 1, E_GAP);
    add(B_NO, 3, E_IDLE);
    // Left pressed during center's hold is ignored until center ends.
    add(B_CN, 6, E_IDLE);
    add(B_CN, 1, E_CN);
    add(B_CN | B_LF, 10, E_CN);
    add(B_LF, 6, E_CN);
    add(B_LF, 1, E_GAP);
    add(B_LF, 1, E_IDLE);
    add(B_LF, 1, E_LF);
    add(B_NO, 7, E_LF);
    add(B_NO, 1, E_GAP);
    add(B_NO, 3, E_IDLE);

    foreach (tbl[i]) begin
      drive(tbl[i].btn);
      for (int k = 0; k < tbl[i].n; k++) begin
        step();
        check("table", i, tbl[i].exp);
      end
    end

    // Reset asserted while up is active drops outputs without a clock edge.
    drive(B_UP);
    for (int k = 1; k <= 7; k++) begin
      step();
      check("pre_reset", k, (k >= 7) ? E_UP : E_IDLE);
    end
    #2;
    rst = 1'b0;
    #1;
    check("async_reset", 0, E_IDLE);
    drive(B_NO);
    step();
    check("async_reset", 1, E_IDLE);
    rst = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      check("post_reset", k, E_IDLE);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
